// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: ALU opcodes, FSM states,
// major opcodes and datapath mux selects.
package riscv_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_XOR = 4'b1000;
   localparam logic [3:0] ALU_BNE = 4'b1001;
   localparam logic [3:0] ALU_BEQ = 4'b1010;
   localparam logic [3:0] ALU_BLT = 4'b1011;
   localparam logic [3:0] ALU_BGE = 4'b1100;
   localparam logic [3:0] ALU_LUI = 4'b1101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
      S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_LUI_ST, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_4     = 2'b10;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR, memory handshake, ALU flags in; mux selects and enables out.
interface riscv_multicycle_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
);
   logic [WIDTH-1:0] instr;
   logic             mem_ready;
   logic             Equal;
   logic             NEqual;
   logic             Less_Than;
   logic             Greater_Equal;
   logic [3:0]       alu_op;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [2:0]       imm_src;
   logic [1:0]       result_src;
   logic             adr_src;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             pc_write;
   logic             reg_write;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  instr, mem_ready, Equal, NEqual, Less_Than, Greater_Equal,
      output alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
             mem_read, mem_write, ir_write, pc_write, reg_write, illegal, retired
   );

   modport slave (
      output instr, mem_ready, Equal, NEqual, Less_Than, Greater_Equal,
      input  alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
             mem_read, mem_write, ir_write, pc_write, reg_write, illegal, retired
   );
endinterface

// File: rtl/alu_op_decoder.sv
// Maps funct3/funct7[5] to the 4-bit ALU opcode for R/I arithmetic and branch compares.
module alu_op_decoder (
   input  logic       i_is_r,
   input  logic       i_is_branch,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   output logic [3:0] o_alu_op,
   output logic       o_valid
);
   import riscv_ctrl_pkg::*;

   always_comb begin
      o_alu_op = ALU_ADD;
      o_valid  = 1'b1;
      if (i_is_branch) begin
         case (i_funct3)
            3'b000:  o_alu_op = ALU_BEQ;
            3'b001:  o_alu_op = ALU_BNE;
            3'b100:  o_alu_op = ALU_BLT;
            3'b101:  o_alu_op = ALU_BGE;
            default: o_valid  = 1'b0;
         endcase
      end else begin
         // funct7[5] only selects SUB for register-register; for addi it is an immediate bit
         case (i_funct3)
            3'b000:  o_alu_op = (i_is_r && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_op = ALU_SLL;
            3'b010:  o_alu_op = ALU_SLT;
            3'b100:  o_alu_op = ALU_XOR;
            3'b101:  o_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_op = ALU_OR;
            3'b111:  o_alu_op = ALU_AND;
            default: o_valid  = 1'b0;
         endcase
      end
   end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving datapath muxes, enables and the ALU opcode.
// States: FETCH ifetch | DECODE branch target | MEMADR/MEMRD/MEMWB/MEMWR load-store | EXEC_R/EXEC_I alu
//         | ALUWB rd write | BRANCH compare | JAL link | LUI_ST upper imm | TRAP dead until reset
module riscv_multicycle_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input logic                     clk,
   input logic                     rst,
   riscv_multicycle_ctrl_if.master bus
);
   import riscv_ctrl_pkg::*;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_retired;
   logic             r_illegal;
   logic [WIDTH-1:0] w_instr;
   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic             w_funct7_5;
   logic             w_is_r;
   logic             w_is_branch;
   logic [3:0]       w_dec_op;
   logic             w_dec_valid;
   logic             w_flag;
   logic             w_unused_instr;

   assign w_instr        = bus.instr;
   assign w_opcode       = w_instr[6:0];
   assign w_funct3       = w_instr[14:12];
   assign w_funct7_5     = w_instr[30];
   assign w_unused_instr = ^{w_instr[WIDTH-1:31], w_instr[29:15], w_instr[11:7]};
   assign w_is_r         = (r_state == S_EXEC_R);
   assign w_is_branch    = (r_state == S_BRANCH);

   alu_op_decoder u_alu_op_decoder (
      .i_is_r      (w_is_r),
      .i_is_branch (w_is_branch),
      .i_funct3    (w_funct3),
      .i_funct7_5  (w_funct7_5),
      .o_alu_op    (w_dec_op),
      .o_valid     (w_dec_valid)
   );

   always_comb begin
      case (w_funct3)
         3'b000:  w_flag = bus.Equal;
         3'b001:  w_flag = bus.NEqual;
         3'b100:  w_flag = bus.Less_Than;
         3'b101:  w_flag = bus.Greater_Equal;
         default: w_flag = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         // FETCH only self-loops and TRAP never exits, so any other entry to FETCH is a retirement
         if (w_next == S_FETCH && r_state != S_FETCH) r_retired <= r_retired + CNT_W'(1);
         if (w_next == S_TRAP) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next         = r_state;
      bus.alu_op     = ALU_ADD;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.imm_src    = IMM_I;
      bus.result_src = RES_ALUOUT;
      bus.adr_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.reg_write  = 1'b0;
      case (r_state)
         S_FETCH: begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_write   = 1'b1;
               bus.pc_write   = 1'b1;
               bus.alu_src_b  = SRCB_4;
               bus.result_src = RES_ALU;
               w_next         = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
            bus.imm_src   = IMM_B;
            case (w_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:              w_next = S_EXEC_R;
               OP_I:              w_next = S_EXEC_I;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_LUI:            w_next = S_LUI_ST;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
            bus.imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
            w_next        = (w_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.adr_src  = 1'b1;
            bus.mem_read = 1'b1;
            if (bus.mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            bus.result_src = RES_DATA;
            bus.reg_write  = 1'b1;
            w_next         = S_FETCH;
         end
         S_MEMWR: begin
            bus.adr_src   = 1'b1;
            bus.mem_write = 1'b1;
            if (bus.mem_ready) w_next = S_FETCH;
         end
         S_EXEC_R, S_EXEC_I: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = (r_state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
            bus.alu_op    = w_dec_op;
            w_next        = w_dec_valid ? S_ALUWB : S_TRAP;
         end
         S_ALUWB: begin
            bus.reg_write = 1'b1;
            w_next        = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_op    = w_dec_op;
            bus.pc_write  = w_flag & w_dec_valid;
            w_next        = w_dec_valid ? S_FETCH : S_TRAP;
         end
         S_JAL: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_4;
            bus.pc_write  = 1'b1;
            w_next        = S_ALUWB;
         end
         S_LUI_ST: begin
            bus.alu_src_b = SRCB_IMM;
            bus.imm_src   = IMM_U;
            bus.alu_op    = ALU_LUI;
            w_next        = S_ALUWB;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
      if (rst) begin
         bus.alu_op     = ALU_ADD;
         bus.alu_src_a  = '0;
         bus.alu_src_b  = '0;
         bus.imm_src    = '0;
         bus.result_src = '0;
         bus.adr_src    = 1'b0;
         bus.mem_read   = 1'b0;
         bus.mem_write  = 1'b0;
         bus.ir_write   = 1'b0;
         bus.pc_write   = 1'b0;
         bus.reg_write  = 1'b0;
      end
   end

   assign bus.illegal = r_illegal;
   assign bus.retired = r_retired;

endmodule
